// File: rtl/pong_match_ctrl_if.sv
// rtl/pong_match_ctrl_if.sv - signal bundle between match controller and its environment
interface pong_match_ctrl_if;
    logic       btn_start;
    logic       frame_tick;
    logic       miss_left;
    logic       miss_right;
    logic       paddle_hit;
    logic       speed_sel;
    logic       ball_en;
    logic       ball_hold;
    logic       serve_dir;
    logic       speed_fast;
    logic [3:0] score_l;
    logic [3:0] score_r;
    logic [1:0] winner;
    logic [2:0] state;

    // environment side: drives button, timing and ball events, observes match outputs
    modport master (
        output btn_start, frame_tick, miss_left, miss_right, paddle_hit, speed_sel,
        input  ball_en, ball_hold, serve_dir, speed_fast, score_l, score_r, winner, state
    );

    // controller side
    modport slave (
        input  btn_start, frame_tick, miss_left, miss_right, paddle_hit, speed_sel,
        output ball_en, ball_hold, serve_dir, speed_fast, score_l, score_r, winner, state
    );
endinterface

// File: rtl/pong_match_ctrl.sv
// rtl/pong_match_ctrl.sv - pong match sequencer; optional rally speed-up under PONG_AUTO_SPEEDUP_EN
module pong_match_ctrl #(
    parameter int WIN_SCORE    = 3,
    parameter int SERVE_FRAMES = 60,
    parameter int POINT_FRAMES = 90,
    parameter int HITS_FAST    = 8
) (
    input  logic              vga_clk,
    input  logic              sys_rst,
    pong_match_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_POINT = 3'd3,
        ST_OVER  = 3'd4
    } state_t;

    localparam logic [3:0] WIN_VAL    = 4'(WIN_SCORE);
    localparam logic [7:0] SERVE_LAST = 8'(SERVE_FRAMES - 1);
    localparam logic [7:0] POINT_LAST = 8'(POINT_FRAMES - 1);

    state_t     state_q, state_d;
    logic [7:0] frame_q, frame_d;
    logic [3:0] score_l_q, score_l_d;
    logic [3:0] score_r_q, score_r_d;
    logic [1:0] winner_q, winner_d;
    logic       serve_q, serve_d;
    logic       en_q, en_d;
    logic       hold_q, hold_d;
    logic       fast_q, fast_d;
    logic       btn_prev_q;
    logic       start_evt;

`ifdef PONG_AUTO_SPEEDUP_EN
    logic [3:0] hit_q, hit_d;
`else
    logic       unused_paddle_hit;
    assign unused_paddle_hit = bus.paddle_hit;
`endif

    // state and all output registers; reset leaves the ball parked at centre
    always_ff @(posedge vga_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q    <= ST_IDLE;
            frame_q    <= '0;
            score_l_q  <= '0;
            score_r_q  <= '0;
            winner_q   <= 2'b00;
            serve_q    <= 1'b1;
            en_q       <= 1'b0;
            hold_q     <= 1'b1;
            fast_q     <= 1'b0;
            btn_prev_q <= 1'b1;
`ifdef PONG_AUTO_SPEEDUP_EN
            hit_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            frame_q    <= frame_d;
            score_l_q  <= score_l_d;
            score_r_q  <= score_r_d;
            winner_q   <= winner_d;
            serve_q    <= serve_d;
            en_q       <= en_d;
            hold_q     <= hold_d;
            fast_q     <= fast_d;
            btn_prev_q <= bus.btn_start;
`ifdef PONG_AUTO_SPEEDUP_EN
            hit_q      <= hit_d;
`endif
        end
    end

    // next-state, scoring and the next value of every registered output
    always_comb begin
        state_d   = state_q;
        score_l_d = score_l_q;
        score_r_d = score_r_q;
        winner_d  = winner_q;
        serve_d   = serve_q;
        start_evt = bus.btn_start & ~btn_prev_q;

        case (state_q)
            ST_IDLE: begin
                if (start_evt) begin
                    score_l_d = '0;
                    score_r_d = '0;
                    winner_d  = 2'b00;
                    state_d   = ST_SERVE;
                end
            end
            ST_SERVE: begin
                if (bus.frame_tick && frame_q == SERVE_LAST) begin
                    state_d = ST_PLAY;
                end
            end
            ST_PLAY: begin
                // a miss wins over a coincident frame tick; the tick is simply dropped
                if (bus.miss_left && bus.miss_right) begin
                    serve_d = ~serve_q;
                    state_d = ST_SERVE;
                end else if (bus.miss_right) begin
                    if (score_l_q < WIN_VAL) begin
                        score_l_d = score_l_q + 4'd1;
                    end
                    serve_d = 1'b1;
                    state_d = ST_POINT;
                end else if (bus.miss_left) begin
                    if (score_r_q < WIN_VAL) begin
                        score_r_d = score_r_q + 4'd1;
                    end
                    serve_d = 1'b0;
                    state_d = ST_POINT;
                end
            end
            ST_POINT: begin
                if (bus.frame_tick && frame_q == POINT_LAST) begin
                    if (score_l_q == WIN_VAL) begin
                        winner_d = 2'b01;
                        state_d  = ST_OVER;
                    end else if (score_r_q == WIN_VAL) begin
                        winner_d = 2'b10;
                        state_d  = ST_OVER;
                    end else begin
                        state_d  = ST_SERVE;
                    end
                end
            end
            ST_OVER: begin
                if (start_evt) begin
                    score_l_d = '0;
                    score_r_d = '0;
                    winner_d  = 2'b00;
                    serve_d   = 1'b1;
                    state_d   = ST_SERVE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // frame pacing restarts on every state change and only counts in the timed states
        if (state_d != state_q) begin
            frame_d = '0;
        end else if (bus.frame_tick && (state_q == ST_SERVE || state_q == ST_POINT)) begin
            frame_d = frame_q + 8'd1;
        end else begin
            frame_d = frame_q;
        end

        en_d   = (state_d == ST_PLAY);
        hold_d = ~en_d;

`ifdef PONG_AUTO_SPEEDUP_EN
        // rally length resets at each serve and saturates so long rallies stay fast
        if (state_d == ST_SERVE && state_q != ST_SERVE) begin
            hit_d = '0;
        end else if (state_q == ST_PLAY && bus.paddle_hit && hit_q != 4'hF) begin
            hit_d = hit_q + 4'd1;
        end else begin
            hit_d = hit_q;
        end
        fast_d = bus.speed_sel | ({1'b0, hit_d} >= 5'(HITS_FAST));
`else
        fast_d = bus.speed_sel;
`endif
    end

    assign bus.state      = state_q;
    assign bus.ball_en    = en_q;
    assign bus.ball_hold  = hold_q;
    assign bus.serve_dir  = serve_q;
    assign bus.speed_fast = fast_q;
    assign bus.score_l    = score_l_q;
    assign bus.score_r    = score_r_q;
    assign bus.winner     = winner_q;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// tb/tb_pong_match_ctrl.sv - scoreboard bench for pong_match_ctrl
module tb_pong_match_ctrl;

    localparam logic [5:0] B  = 6'b100000;
    localparam logic [5:0] T  = 6'b010000;
    localparam logic [5:0] ML = 6'b001000;
    localparam logic [5:0] MR = 6'b000100;
    localparam logic [5:0] PH = 6'b000010;
    localparam logic [5:0] SS = 6'b000001;

`ifdef PONG_AUTO_SPEEDUP_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    typedef struct {
        int          due;
        logic [16:0] exp;
        string       nm;
    } rec_t;

    logic vga_clk = 1'b0;
    logic sys_rst = 1'b1;
    logic imm_tgl = 1'b0;
    int   cyc_n   = 0;
    int   checks  = 0;
    int   errors  = 0;
    rec_t q[$];

    pong_match_ctrl_if m ();

    pong_match_ctrl #(
        .WIN_SCORE    (3),
        .SERVE_FRAMES (2),
        .POINT_FRAMES (2),
        .HITS_FAST    (8)
    ) dut (
        .vga_clk (vga_clk),
        .sys_rst (sys_rst),
        .bus     (m)
    );

    always #5 vga_clk = ~vga_clk;

    always @(posedge vga_clk) cyc_n <= cyc_n + 1;

    function automatic logic [16:0] mk(input logic [2:0] st, input logic dir, input logic fast,
                                       input logic [3:0] sl, input logic [3:0] sr, input logic [1:0] w);
        logic en;
        en = (st == 3'd2);
        return {st, en, ~en, dir, fast, sl, sr, w};
    endfunction

    task automatic drive(input logic [5:0] v);
        m.btn_start  = v[5];
        m.frame_tick = v[4];
        m.miss_left  = v[3];
        m.miss_right = v[2];
        m.paddle_hit = v[1];
        m.speed_sel  = v[0];
    endtask

    // apply inputs for the next edge and queue what the outputs must become after it
    task automatic step(input logic [5:0] v, input logic [16:0] e, input string nm);
        rec_t r;
        drive(v);
        r.due = cyc_n + 1;
        r.exp = e;
        r.nm  = nm;
        q.push_back(r);
        @(negedge vga_clk);
        #1;
    endtask

    // queue a reset-value expectation that must hold now, before any further edge
    task automatic check_now(input string nm);
        rec_t r;
        r.due = cyc_n;
        r.exp = mk(3'd0, 1'b1, 1'b0, 4'd0, 4'd0, 2'b00);
        r.nm  = nm;
        q.push_back(r);
        #1;
        imm_tgl = ~imm_tgl;
        #1;
    endtask

    // monitor: compare every due expectation away from the active edge
    always begin
        logic [16:0] act;
        rec_t        r;
        @(negedge vga_clk or imm_tgl);
        while (q.size() > 0 && q[0].due <= cyc_n) begin
            r   = q.pop_front();
            act = {m.state, m.ball_en, m.ball_hold, m.serve_dir, m.speed_fast,
                   m.score_l, m.score_r, m.winner};
            checks = checks + 1;
            if (act !== r.exp) begin
                errors = errors + 1;
                $display("FAIL %s got %h exp %h", r.nm, act, r.exp);
            end
        end
    end

    initial begin
        drive(B);
        @(negedge vga_clk);
        #1;
        check_now("reset_vals");
        @(negedge vga_clk);
        #1;
        sys_rst = 1'b0;

        step(B, mk(0, 1, 0, 0, 0, 0), "held_btn0");
        step(B, mk(0, 1, 0, 0, 0, 0), "held_btn1");
        step(0, mk(0, 1, 0, 0, 0, 0), "btn_low");
        step(B, mk(1, 1, 0, 0, 0, 0), "start");
        step(B, mk(1, 1, 0, 0, 0, 0), "serve_wait");
        step(B | T, mk(1, 1, 0, 0, 0, 0), "serve_tick1");
        step(B | T, mk(2, 1, 0, 0, 0, 0), "play");

        step(B | MR, mk(3, 1, 0, 1, 0, 0), "miss_r");
        step(B | T, mk(3, 1, 0, 1, 0, 0), "point_tick1");
        step(B | T, mk(1, 1, 0, 1, 0, 0), "point_done");
        step(T, mk(1, 1, 0, 1, 0, 0), "serve_t1");
        step(T, mk(2, 1, 0, 1, 0, 0), "play2");

        step(ML | MR, mk(1, 0, 0, 1, 0, 0), "double_miss");
        step(T, mk(1, 0, 0, 1, 0, 0), "serve_t1b");
        step(T, mk(2, 0, 0, 1, 0, 0), "play3");

        for (int k = 1; k <= 3; k++) begin
            step(ML, mk(3, 0, 0, 1, 4'(k), 0), "miss_l");
            step(T, mk(3, 0, 0, 1, 4'(k), 0), "pt_t1");
            if (k < 3) begin
                step(T, mk(1, 0, 0, 1, 4'(k), 0), "pt_serve");
                step(T, mk(1, 0, 0, 1, 4'(k), 0), "sv_t1");
                step(T, mk(2, 0, 0, 1, 4'(k), 0), "sv_play");
            end
        end
        step(T, mk(4, 0, 0, 1, 3, 2'b10), "win_r");
        step(ML | MR | T, mk(4, 0, 0, 1, 3, 2'b10), "over_ignore");
        step(B, mk(1, 1, 0, 0, 0, 0), "restart");
        step(B | T, mk(1, 1, 0, 0, 0, 0), "rs_t1");
        step(T, mk(2, 1, 0, 0, 0, 0), "rs_play");
        step(B, mk(2, 1, 0, 0, 0, 0), "start_ignored");

        step(MR, mk(3, 1, 0, 1, 0, 0), "l1");
        step(T, mk(3, 1, 0, 1, 0, 0), "l1_t1");
        step(T, mk(1, 1, 0, 1, 0, 0), "l1_serve");
        step(T, mk(1, 1, 0, 1, 0, 0), "l1_s1");
        step(T, mk(2, 1, 0, 1, 0, 0), "l1_play");
        step(MR | T, mk(3, 1, 0, 2, 0, 0), "tick_discard");
        step(T, mk(3, 1, 0, 2, 0, 0), "l2_t1");
        step(T, mk(1, 1, 0, 2, 0, 0), "l2_serve");
        step(T, mk(1, 1, 0, 2, 0, 0), "l2_s1");
        step(T, mk(2, 1, 0, 2, 0, 0), "l2_play");

        step(SS, mk(2, 1, 1, 2, 0, 0), "speed_sel_on");
        step(0, mk(2, 1, 0, 2, 0, 0), "speed_sel_off");
        for (int i = 1; i <= 8; i++) begin
            step(PH, mk(2, 1, AUTO && (i >= 8), 2, 0, 0), "paddle_hit");
        end
        step(ML | MR, mk(1, 0, 0, 2, 0, 0), "serve_clears_fast");
        step(T, mk(1, 0, 0, 2, 0, 0), "f_s1");
        step(T, mk(2, 0, 0, 2, 0, 0), "f_play");

        drive(0);
        sys_rst = 1'b1;
        check_now("reset_mid_play");
        @(negedge vga_clk);
        #1;
        sys_rst = 1'b0;
        step(0, mk(0, 1, 0, 0, 0, 0), "after_reset");

        for (int w = 0; w < 10 && q.size() > 0; w++) begin
            @(negedge vga_clk);
            #1;
        end
        if (q.size() > 0) begin
            errors = errors + 1;
            $display("FAIL drain got %0d pending exp 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pong_match_ctrl.md
Name: pong_match_ctrl

Overview:
- Match-level sequencer for the pong game.
- Decides when the ball mover runs, when the ball is held at centre, and which way it serves.
- Keeps both players' scores and declares a winner.
- Sits between the start button / frame timing and the ball mover; consumes the mover's edge-miss and paddle-hit pulses.

Parameters:
- WIN_SCORE, 3, points needed to win (1..15).
- SERVE_FRAMES, 60, frame ticks the ball is held at centre before each serve (>=1).
- POINT_FRAMES, 90, frame ticks of pause after a point (>=1).
- HITS_FAST, 8, paddle hits in one rally before fast speed is selected (used only with the optional feature).

Ports:
- vga_clk  in  1  pixel clock; the only clock.
- sys_rst  in  1  asynchronous, active-high reset.
- btn_start  in  1  start button level, already synchronised.
- frame_tick  in  1  one-cycle pulse per video frame.
- miss_left  in  1  one-cycle pulse: ball passed the left edge.
- miss_right  in  1  one-cycle pulse: ball passed the right edge.
- paddle_hit  in  1  one-cycle pulse: ball bounced off either paddle.
- speed_sel  in  1  manual speed switch.
- ball_en  out  1  ball mover may advance.
- ball_hold  out  1  force ball to centre.
- serve_dir  out  1  initial x direction: 1 = right, 0 = left.
- speed_fast  out  1  selects the fast ball divider.
- score_l  out  4  left player score.
- score_r  out  4  right player score.
- winner  out  2  00 none, 01 left, 10 right.
- state  out  3  current state, for debug and display.

Behaviour:
- All outputs are registered. Every response appears on the cycle after the causing input is sampled.
- Reset values: state=IDLE(0), ball_en=0, ball_hold=1, serve_dir=1, speed_fast=0, score_l=0, score_r=0, winner=00, frame counter=0, hit counter=0.
- Reset also sets btn_prev=1, so a button held through reset release is not taken as a press.
- Reset mid-operation returns every register to its reset value immediately.
- Start edge: start_evt = btn_start & ~btn_prev; btn_prev is updated every cycle.
- Frame counter: 8 bits. Cleared on every state change; increments on frame_tick while in SERVE or POINT.
- States (encoding):
  - IDLE(0): hold=1, en=0. On start_evt: clear scores, winner=00 -> SERVE.
  - SERVE(1): hold=1, en=0. When a frame_tick arrives with counter==SERVE_FRAMES-1 -> PLAY.
  - PLAY(2): hold=0, en=1. Handled per the miss rules below.
  - POINT(3): hold=1, en=0. When a frame_tick arrives with counter==POINT_FRAMES-1:
    - if score_l==WIN_SCORE: winner=01 -> OVER;
    - else if score_r==WIN_SCORE: winner=10 -> OVER;
    - else -> SERVE.
  - OVER(4): hold=1, en=0, winner held. On start_evt: clear scores, winner=00, serve_dir=1 -> SERVE.
- Miss rules in PLAY:
  - miss_right alone: score_r unchanged; score_l+1; serve_dir=1 (serve toward the conceder); -> POINT.
  - miss_left alone: score_r+1; serve_dir=0; -> POINT.
  - miss_left and miss_right in the same cycle: no score change; serve_dir toggles; -> SERVE.
  - Misses outside PLAY are ignored.
- Scores never exceed WIN_SCORE; an increment at WIN_SCORE saturates.
- start_evt in SERVE, PLAY or POINT is ignored.
- frame_tick and a miss in the same PLAY cycle: the miss rules apply; the tick is discarded.
- Unused state encodings 5..7 go to IDLE on the next clock.

Optional Feature:
- Macro: PONG_AUTO_SPEEDUP_EN.
- Defined:
  - 4-bit hit counter, cleared on entry to SERVE.
  - Increments on paddle_hit in PLAY, saturating at 15.
  - speed_fast = speed_sel | (hit_count >= HITS_FAST), registered.
- Undefined:
  - no hit counter; paddle_hit is unused.
  - speed_fast = registered speed_sel.

Test Plan (WIN_SCORE=3, SERVE_FRAMES=2, POINT_FRAMES=2):
- Reset with btn_start=1, release reset, keep button held -> stays IDLE, hold=1. Drop then raise button -> SERVE one cycle after the rise; after 2 frame_ticks -> PLAY, en=1, hold=0.
- In PLAY pulse miss_right -> next cycle score_l=1, serve_dir=1, state=POINT, en=0. After 2 ticks -> SERVE.
- Pulse miss_left and miss_right in the same cycle with serve_dir=1 -> scores unchanged, serve_dir=0, state=SERVE.
- Three miss_left points -> score_r=3; after the POINT pause winner=10, state=OVER. A start press -> scores 0, winner=00, SERVE.
- Assert sys_rst mid-PLAY with score_l=2 -> all outputs at reset values immediately, without waiting for a clock edge.
- With PONG_AUTO_SPEEDUP_EN defined and speed_sel=0: 7 paddle_hits -> speed_fast=0; 8th -> speed_fast=1 next cycle. After a miss, on entry to SERVE -> speed_fast=0 again.
